alu_op_sequencer: RTL and testbench
===================================

# alu_op_sequencer

Command-side front end for the 32-bit ALU. It accepts ALU operations over a valid/ready command port and buffers them in a small FIFO. It issues each one to the ALU's operand and select inputs, captures result and overflow, and returns them over a valid/ready response port. It sits between the control/issue logic and the combinational ALU, adding ordering, backpressure and overflow masking.

## Interface
- DEPTH, 4, command FIFO entries; power of two, ≥2
- CNT_W, 16, width of completed-operation counter
- clk  input  1  single clock, rising edge
- rst_n  input  1  reset, asynchronous, active-low
- cmd_valid  input  1  command present
- cmd_ready  output  1  FIFO can accept; equals !fifo_full
- cmd_sel  input  4  ALU operation code
- cmd_a  input  32  operand 1
- cmd_b  input  32  operand 2 (shifts use bits [4:0])
- alu_inp_1  output  32  registered operand 1 to ALU
- alu_inp_2  output  32  registered operand 2 to ALU
- alu_sel  output  4  registered select to ALU
- alu_result  input  32  ALU result
- alu_overflow  input  1  ALU overflow
- rsp_valid  output  1  response present
- rsp_ready  input  1  consumer accepts response
- rsp_data  output  32  captured result
- rsp_ovf  output  1  masked overflow
- rsp_err  output  1  command had an unsupported select code
- op_count  output  CNT_W  completed responses, wraps

## Operation
- Valid codes: 0000 COMPLEMENT, 0001 AND, 0010 XOR, 0011 OR, 0100 DEC, 0101 ADD, 0110 SUB, 0111 INC, 1000 EQ, 1001 SLL, 1010 SRL. Codes 1011–1111 are invalid.
- FIFO push on cmd_valid && cmd_ready. No push while full, even if a pop occurs in the same cycle.
- FSM states and transitions:
  - IDLE: if FIFO is non-empty, pop the head into alu_inp_1/alu_inp_2/alu_sel, then go to DRIVE.
  - DRIVE: a single cycle in which the ALU settles. At the clock edge, capture rsp_* and set rsp_valid, then go to RESP.
  - RESP: hold all rsp_* until rsp_valid && rsp_ready. On that handshake, clear rsp_valid and increment op_count. Then pop the next entry and go to DRIVE if the FIFO is non-empty, otherwise go to IDLE.
- Capture rules:
  - rsp_data = alu_result for valid codes, 0 for invalid codes.
  - rsp_ovf = alu_overflow only for 0101/0111, otherwise 0. The ALU's overflow output is not defined for other codes.
  - rsp_err = 1 only for invalid codes.
- alu_* registers hold their last value outside DRIVE.
- Responses are returned in command order.
- rsp_ready while rsp_valid=0 is ignored.
- op_count wraps from all-ones to 0.

## Timing
- Reset values: alu_inp_1=0, alu_inp_2=0, alu_sel=0000, rsp_valid=0, rsp_data=0, rsp_ovf=0, rsp_err=0, op_count=0, FIFO empty, so cmd_ready=1, FSM=IDLE.
- Latency: command accepted at edge T0 → popped at T1 → rsp_valid high after T2 (2 cycles).
- Throughput: with rsp_ready held high, one response every 2 cycles. rsp_valid pulses on alternate cycles.
- cmd_ready is combinational from FIFO occupancy only. It has no dependency on cmd_valid or rsp_ready.
- rsp_* are stable while rsp_valid=1 and no handshake has occurred.
- Reset mid-operation: the FIFO and any in-flight operation are discarded. All outputs take their reset values immediately (asynchronous reset).
- FIFO pointers are log2(DEPTH) bits wide and wrap. Occupancy uses an extra bit to distinguish full from empty.

## Test plan
- ADD overflow: push sel=0101, a=0x7FFFFFFF, b=1 with rsp_ready=1 → rsp_valid 2 cycles after accept, rsp_data=0x80000000, rsp_ovf=1, rsp_err=0, op_count=1.
- SUB masking: sel=0110, a=5, b=7 → rsp_data=0xFFFFFFFE, rsp_ovf=0. Then sel=0111, a=0x7FFFFFFF → rsp_data=0x80000000, rsp_ovf=1.
- Backpressure (DEPTH=4): hold rsp_ready=0 and push commands every cycle → 5 accepted (1 in RESP, 4 in FIFO), cmd_ready=0 on the 6th. Then release rsp_ready → 5 responses in order, every 2 cycles, op_count=5.
- Invalid code: sel=1100, a=0x1234, b=0x5678 → rsp_data=0, rsp_ovf=0, rsp_err=1. The next valid command returns rsp_err=0.
- Shift masking: sel=1001, a=1, b=0x00000025 → rsp_data=0x00000020. sel=1010, a=0x80000000, b=31 → rsp_data=1.
- Reset mid-op: assert rst_n=0 while in RESP with 2 entries queued → rsp_valid=0, cmd_ready=1, op_count=0 immediately. After release, no stale responses appear.

Source files
------------

// File: rtl/alu_op_sequencer_if.sv
// Command and response handshake bundle between the issue logic and the ALU sequencer.
// master = issuer/consumer side, slave = sequencer side.
interface alu_op_sequencer_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [3:0]  cmd_sel;
  logic [31:0] cmd_a;
  logic [31:0] cmd_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_ovf;
  logic        rsp_err;

  modport master (
    output cmd_valid, cmd_sel, cmd_a, cmd_b, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data, rsp_ovf, rsp_err
  );

  modport slave (
    input  cmd_valid, cmd_sel, cmd_a, cmd_b, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data, rsp_ovf, rsp_err
  );
endinterface

// File: rtl/alu_op_sequencer.sv
// Buffers ALU commands in a FIFO, issues them one at a time to the combinational ALU,
// and returns the captured result with overflow masking over a valid/ready response port.
module alu_op_sequencer #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  alu_op_sequencer_if.slave    bus,
  output logic [31:0]          alu_inp_1,
  output logic [31:0]          alu_inp_2,
  output logic [3:0]           alu_sel,
  input  logic [31:0]          alu_result,
  input  logic                 alu_overflow,
  output logic [CNT_W-1:0]     op_count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  typedef struct packed {
    logic [3:0]  sel;
    logic [31:0] a;
    logic [31:0] b;
  } cmd_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_RESP  = 2'd2
  } state_t;

  cmd_t               fifo_mem_r [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_r;
  logic [PTR_W-1:0]   rd_ptr_r;
  logic [PTR_W:0]     count_r;
  state_t             state_r;
  logic [31:0]        alu_inp_1_r;
  logic [31:0]        alu_inp_2_r;
  logic [3:0]         alu_sel_r;
  logic               rsp_valid_r;
  logic [31:0]        rsp_data_r;
  logic               rsp_ovf_r;
  logic               rsp_err_r;
  logic [CNT_W-1:0]   op_count_r;
  logic               full_s;
  logic               empty_s;
  logic               push_s;
  logic               pop_s;
  cmd_t               head_s;

  function automatic logic is_valid_code(input logic [3:0] sel);
    return (sel <= 4'd10);
  endfunction

  // Only ADD and INC define a meaningful overflow flag.
  function automatic logic is_ovf_code(input logic [3:0] sel);
    return (sel == 4'b0101) || (sel == 4'b0111);
  endfunction

  assign full_s        = (count_r == FULL_CNT);
  assign empty_s       = (count_r == '0);
  assign push_s        = bus.cmd_valid && !full_s;
  assign head_s        = fifo_mem_r[rd_ptr_r];
  assign bus.cmd_ready = !full_s;
  assign bus.rsp_valid = rsp_valid_r;
  assign bus.rsp_data  = rsp_data_r;
  assign bus.rsp_ovf   = rsp_ovf_r;
  assign bus.rsp_err   = rsp_err_r;
  assign alu_inp_1     = alu_inp_1_r;
  assign alu_inp_2     = alu_inp_2_r;
  assign alu_sel       = alu_sel_r;
  assign op_count      = op_count_r;

  // Pop the head when idle, or right as the current response is handed off.
  always_comb begin
    pop_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (!empty_s) pop_s = 1'b1;
        else          pop_s = 1'b0;
      end
      ST_RESP: begin
        if (rsp_valid_r && bus.rsp_ready && !empty_s) pop_s = 1'b1;
        else                                          pop_s = 1'b0;
      end
      default: pop_s = 1'b0;
    endcase
  end

  // FIFO storage; stale entries are harmless because the pointers gate visibility.
  always_ff @(posedge clk) begin
    if (push_s) fifo_mem_r[wr_ptr_r] <= '{sel: bus.cmd_sel, a: bus.cmd_a, b: bus.cmd_b};
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + PTR_W'(1'b1);
      if (pop_s)  rd_ptr_r <= rd_ptr_r + PTR_W'(1'b1);
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + (PTR_W+1)'(1'b1);
        2'b01:   count_r <= count_r - (PTR_W+1)'(1'b1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Issue/capture/respond state machine with registered ALU and response outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      alu_inp_1_r <= 32'd0;
      alu_inp_2_r <= 32'd0;
      alu_sel_r   <= 4'b0000;
      rsp_valid_r <= 1'b0;
      rsp_data_r  <= 32'd0;
      rsp_ovf_r   <= 1'b0;
      rsp_err_r   <= 1'b0;
      op_count_r  <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (pop_s) begin
            alu_inp_1_r <= head_s.a;
            alu_inp_2_r <= head_s.b;
            alu_sel_r   <= head_s.sel;
            state_r     <= ST_DRIVE;
          end else begin
            state_r     <= ST_IDLE;
          end
        end
        ST_DRIVE: begin
          rsp_data_r  <= is_valid_code(alu_sel_r) ? alu_result : 32'd0;
          rsp_ovf_r   <= is_ovf_code(alu_sel_r) ? alu_overflow : 1'b0;
          rsp_err_r   <= !is_valid_code(alu_sel_r);
          rsp_valid_r <= 1'b1;
          state_r     <= ST_RESP;
        end
        ST_RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_r <= 1'b0;
            op_count_r  <= op_count_r + CNT_W'(1'b1);
            if (pop_s) begin
              alu_inp_1_r <= head_s.a;
              alu_inp_2_r <= head_s.b;
              alu_sel_r   <= head_s.sel;
              state_r     <= ST_DRIVE;
            end else begin
              state_r     <= ST_IDLE;
            end
          end else begin
            state_r <= ST_RESP;
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          rsp_valid_r <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_alu_op_sequencer.sv
// Scoreboard bench for alu_op_sequencer: directed commands push expected responses,
// a negedge monitor pops and compares whenever a response handshake is presented.
module tb_alu_op_sequencer;
  logic        clk;
  logic        rst_n;
  logic [31:0] alu_inp_1;
  logic [31:0] alu_inp_2;
  logic [3:0]  alu_sel;
  logic [31:0] alu_result;
  logic        alu_overflow;
  logic [15:0] op_count;
  logic [31:0] sum_s;

  int n_tests = 0;
  int n_fail  = 0;
  int n_sent  = 0;
  logic [33:0] exp_q [$];

  alu_op_sequencer_if bus ();

  alu_op_sequencer #(.DEPTH(4), .CNT_W(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus),
    .alu_inp_1    (alu_inp_1),
    .alu_inp_2    (alu_inp_2),
    .alu_sel      (alu_sel),
    .alu_result   (alu_result),
    .alu_overflow (alu_overflow),
    .op_count     (op_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ALU model; overflow is forced high for codes where it is undefined so masking is visible.
  assign sum_s = alu_inp_1 + alu_inp_2;
  always_comb begin
    alu_result   = 32'hDEADBEEF;
    alu_overflow = 1'b1;
    case (alu_sel)
      4'd0:  alu_result = ~alu_inp_1;
      4'd1:  alu_result = alu_inp_1 & alu_inp_2;
      4'd2:  alu_result = alu_inp_1 ^ alu_inp_2;
      4'd3:  alu_result = alu_inp_1 | alu_inp_2;
      4'd4:  alu_result = alu_inp_1 - 32'd1;
      4'd5: begin
        alu_result   = sum_s;
        alu_overflow = (alu_inp_1[31] == alu_inp_2[31]) && (sum_s[31] != alu_inp_1[31]);
      end
      4'd6:  alu_result = alu_inp_1 - alu_inp_2;
      4'd7: begin
        alu_result   = alu_inp_1 + 32'd1;
        alu_overflow = (alu_inp_1 == 32'h7FFFFFFF);
      end
      4'd8:  alu_result = {31'd0, alu_inp_1 == alu_inp_2};
      4'd9:  alu_result = alu_inp_1 << alu_inp_2[4:0];
      4'd10: alu_result = alu_inp_1 >> alu_inp_2[4:0];
      default: alu_result = 32'hDEADBEEF;
    endcase
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Response monitor: compares handshakes against the scoreboard and checks hold stability.
  logic        hold_v = 1'b0;
  logic [33:0] hold_d = 34'd0;
  always @(negedge clk) begin
    logic [33:0] e;
    if (!rst_n) begin
      hold_v = 1'b0;
    end else begin
      if (hold_v) begin
        check("rsp_hold_valid", {31'd0, bus.rsp_valid}, 32'd1);
        check("rsp_hold_data", {30'd0, bus.rsp_err, bus.rsp_ovf}, {30'd0, hold_d[33:32]});
        check("rsp_hold_word", bus.rsp_data, hold_d[31:0]);
      end
      if (bus.rsp_valid && bus.rsp_ready) begin
        hold_v = 1'b0;
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_rsp: got data 0x%08h with no command outstanding", bus.rsp_data);
        end else begin
          e = exp_q.pop_front();
          check("rsp_data", bus.rsp_data, e[31:0]);
          check("rsp_ovf", {31'd0, bus.rsp_ovf}, {31'd0, e[32]});
          check("rsp_err", {31'd0, bus.rsp_err}, {31'd0, e[33]});
        end
      end else if (bus.rsp_valid) begin
        hold_v = 1'b1;
        hold_d = {bus.rsp_err, bus.rsp_ovf, bus.rsp_data};
      end else begin
        hold_v = 1'b0;
      end
    end
  end

  // Present one command and wait (bounded) for its acceptance edge; returns at posedge+1.
  task automatic send(input logic [3:0] sel, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] ed, input logic eo, input logic ee);
    int t = 0;
    bus.cmd_valid = 1'b1;
    bus.cmd_sel   = sel;
    bus.cmd_a     = a;
    bus.cmd_b     = b;
    while (!bus.cmd_ready && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 50) begin
      n_tests++;
      n_fail++;
      $display("FAIL cmd_accept_timeout: cmd_ready stayed 0, expected 1 within 50 cycles");
      bus.cmd_valid = 1'b0;
    end else begin
      exp_q.push_back({ee, eo, ed});
      n_sent++;
      @(posedge clk); #1;
      bus.cmd_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 200) begin
      @(posedge clk);
      t++;
    end
    if (exp_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain_timeout: %0d responses outstanding, expected 0", exp_q.size());
      exp_q.delete();
    end
    repeat (2) @(posedge clk);
    #1;
    check("op_count", {16'd0, op_count}, n_sent);
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_sel   = 4'd0;
    bus.cmd_a     = 32'd0;
    bus.cmd_b     = 32'd0;
    bus.rsp_ready = 1'b0;

    #12;
    check("rst_alu_inp_1", alu_inp_1, 32'd0);
    check("rst_alu_inp_2", alu_inp_2, 32'd0);
    check("rst_alu_sel", {28'd0, alu_sel}, 32'd0);
    check("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    check("rst_rsp_data", bus.rsp_data, 32'd0);
    check("rst_rsp_flags", {30'd0, bus.rsp_ovf, bus.rsp_err}, 32'd0);
    check("rst_op_count", {16'd0, op_count}, 32'd0);
    check("rst_cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // ADD overflow with two-cycle latency
    bus.rsp_ready = 1'b1;
    send(4'b0101, 32'h7FFFFFFF, 32'd1, 32'h80000000, 1'b1, 1'b0);
    @(negedge clk) check("lat_valid_t1", {31'd0, bus.rsp_valid}, 32'd0);
    @(negedge clk) check("lat_valid_t2", {31'd0, bus.rsp_valid}, 32'd0);
    @(negedge clk) check("lat_valid_t3", {31'd0, bus.rsp_valid}, 32'd1);
    @(negedge clk) check("lat_op_count", {16'd0, op_count}, 32'd1);
    @(posedge clk); #1;

    // Overflow masking and the logic/arith codes, back to back
    send(4'b0110, 32'd5, 32'd7, 32'hFFFFFFFE, 1'b0, 1'b0);
    send(4'b0111, 32'h7FFFFFFF, 32'd0, 32'h80000000, 1'b1, 1'b0);
    send(4'b0000, 32'h0F0F0F0F, 32'd0, 32'hF0F0F0F0, 1'b0, 1'b0);
    send(4'b0001, 32'hF0F000FF, 32'h0FF00F0F, 32'h00F0000F, 1'b0, 1'b0);
    send(4'b0010, 32'hAAAA5555, 32'hFFFF0000, 32'h55555555, 1'b0, 1'b0);
    send(4'b0011, 32'h12340000, 32'h00005678, 32'h12345678, 1'b0, 1'b0);
    send(4'b0100, 32'd0, 32'd0, 32'hFFFFFFFF, 1'b0, 1'b0);
    send(4'b1000, 32'd3, 32'd3, 32'd1, 1'b0, 1'b0);
    send(4'b1000, 32'd3, 32'd4, 32'd0, 1'b0, 1'b0);
    send(4'b0101, 32'd1, 32'd2, 32'd3, 1'b0, 1'b0);
    // Invalid codes, then recovery
    send(4'b1100, 32'h1234, 32'h5678, 32'd0, 1'b0, 1'b1);
    send(4'b1011, 32'h7FFFFFFF, 32'd1, 32'd0, 1'b0, 1'b1);
    send(4'b1111, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b0, 1'b1);
    send(4'b0001, 32'h0000FFFF, 32'h000000FF, 32'h000000FF, 1'b0, 1'b0);
    // Shift amount uses only b[4:0]
    send(4'b1001, 32'd1, 32'h00000025, 32'h00000020, 1'b0, 1'b0);
    send(4'b1010, 32'h80000000, 32'd31, 32'd1, 1'b0, 1'b0);
    drain();

    // Backpressure: five accepted (one in RESP, four queued), sixth refused
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      bus.cmd_valid = 1'b1;
      bus.cmd_sel   = 4'b0101;
      bus.cmd_a     = 32'(i + 1);
      bus.cmd_b     = 32'd100;
      @(negedge clk) check($sformatf("bp_cmd_ready_%0d", i), {31'd0, bus.cmd_ready},
                           (i < 5) ? 32'd1 : 32'd0);
      if (i < 5) begin
        exp_q.push_back({1'b0, 1'b0, 32'(101 + i)});
        n_sent++;
      end
      @(posedge clk); #1;
    end
    bus.cmd_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("bp_full_hold", {31'd0, bus.cmd_ready}, 32'd0);
    check("bp_rsp_waiting", {31'd0, bus.rsp_valid}, 32'd1);
    bus.rsp_ready = 1'b1;
    for (int j = 0; j < 10; j++) begin
      @(negedge clk) check($sformatf("bp_cadence_%0d", j), {31'd0, bus.rsp_valid},
                           (j % 2 == 0) ? 32'd1 : 32'd0);
    end
    @(posedge clk); #1;
    drain();

    // Reset while a response is held and two entries are queued
    bus.rsp_ready = 1'b0;
    send(4'b0101, 32'd10, 32'd1, 32'd11, 1'b0, 1'b0);
    send(4'b0101, 32'd20, 32'd1, 32'd21, 1'b0, 1'b0);
    send(4'b0101, 32'd30, 32'd1, 32'd31, 1'b0, 1'b0);
    check("rr_in_resp", {31'd0, bus.rsp_valid}, 32'd1);
    #3 rst_n = 1'b0;
    #1;
    check("rr_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    check("rr_cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);
    check("rr_op_count", {16'd0, op_count}, 32'd0);
    check("rr_alu_inp_1", alu_inp_1, 32'd0);
    exp_q.delete();
    n_sent = 0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk) check($sformatf("rr_no_stale_%0d", k), {31'd0, bus.rsp_valid}, 32'd0);
    end
    @(posedge clk); #1;
    send(4'b0010, 32'hFF00FF00, 32'h0F0F0F0F, 32'hF00FF00F, 1'b0, 1'b0);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
